// File: rtl/gbf_pkg.sv
`default_nettype none
//==============================================================================
// Package : gbf_pkg
// Desc    : Shared GBF geometry defaults and loader state encoding.
// Rev     : 1.0 - initial release
//==============================================================================
package gbf_pkg;

    // Geometry defaults shared with the GBF wrappers
    localparam int GBF_DATA_BITWIDTH_DEF = 256;
    localparam int GBF_ADDR_BITWIDTH_DEF = 5;
    localparam int GBF_DEPTH_DEF         = 32;
    localparam int FILL_LINES_DEF        = 32;
    localparam int CNT_BITWIDTH_DEF      = 16;

    // Loader state encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] FILL1 = 3'd2;
    localparam logic [2:0] FILL2 = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_WAIT  = WAIT,
        ST_FILL1 = FILL1,
        ST_FILL2 = FILL2,
        ST_DONE  = DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gbf_dbuf_loader_if.sv
`default_nettype none
//==============================================================================
// Interface : gbf_dbuf_loader_if
// Desc      : Source line stream plus the two GBF port-a write buses.
//             master = loader side, slave = source / GBF side.
// Rev       : 1.0 - initial release
//==============================================================================
interface gbf_dbuf_loader_if
    import gbf_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DEF,
    parameter int GBF_ADDR_BITWIDTH = GBF_ADDR_BITWIDTH_DEF
);
    // Source stream
    logic                         src_valid;
    logic [GBF_DATA_BITWIDTH-1:0] src_data;
    logic                         src_ready;

    // buf1 write port a
    logic                         en1a;
    logic                         we1a;
    logic [GBF_ADDR_BITWIDTH-1:0] addr1a;
    logic [GBF_DATA_BITWIDTH-1:0] w_data1a;

    // buf2 write port a
    logic                         en2a;
    logic                         we2a;
    logic [GBF_ADDR_BITWIDTH-1:0] addr2a;
    logic [GBF_DATA_BITWIDTH-1:0] w_data2a;

    modport master (
        input  src_valid, src_data,
        output src_ready,
        output en1a, we1a, addr1a, w_data1a,
        output en2a, we2a, addr2a, w_data2a
    );

    modport slave (
        output src_valid, src_data,
        input  src_ready,
        input  en1a, we1a, addr1a, w_data1a,
        input  en2a, we2a, addr2a, w_data2a
    );

endinterface
`default_nettype wire

// File: rtl/gbf_port_driver.sv
`default_nettype none
//==============================================================================
// Module : gbf_port_driver
// Desc   : Registered write port for one GBF buffer, its full flag and the
//          rising-edge detector on the consumer's need_data request.
// Rev    : 1.0 - initial release
//==============================================================================
module gbf_port_driver
    import gbf_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DEF,
    parameter int GBF_ADDR_BITWIDTH = GBF_ADDR_BITWIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr,
    input  logic                         i_set_full,
    input  logic                         i_clear_full,
    input  logic [GBF_ADDR_BITWIDTH-1:0] i_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0] i_data,
    input  logic                         i_need_data,
    output logic                         o_en,
    output logic                         o_we,
    output logic [GBF_ADDR_BITWIDTH-1:0] o_addr,
    output logic [GBF_DATA_BITWIDTH-1:0] o_data,
    output logic                         o_full
);

    logic                         en_q,   en_d;
    logic [GBF_ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [GBF_DATA_BITWIDTH-1:0] data_q, data_d;
    logic                         full_q, full_d;
    logic                         need_q, need_d;
    logic                         w_need_rise;

    // Next-state: one-cycle write pulse, held addr/data, full flag with set priority
    always_comb begin
        en_d        = i_wr;
        addr_d      = addr_q;
        data_d      = data_q;
        full_d      = full_q;
        need_d      = i_need_data;
        w_need_rise = i_need_data & ~need_q;
        if (i_wr) begin
            addr_d = i_addr;
            data_d = i_data;
        end
        // A release edge arriving with the final write is dropped; an edge
        // on an empty buffer has nothing to clear.
        if (i_clear_full) begin
            full_d = 1'b0;
        end else if (i_set_full) begin
            full_d = 1'b1;
        end else if (w_need_rise) begin
            full_d = 1'b0;
        end
    end

    // Port and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            full_q <= 1'b0;
            need_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            full_q <= full_d;
            need_q <= need_d;
        end
    end

    assign o_en   = en_q;
    assign o_we   = en_q;
    assign o_addr = addr_q;
    assign o_data = data_q;
    assign o_full = full_q;

endmodule
`default_nettype wire

// File: rtl/gbf_dbuf_loader.sv
`default_nettype none
//==============================================================================
// Module : gbf_dbuf_loader
// Desc   : Fills a GBF buf1/buf2 pair with fixed-size tiles from a
//          valid/ready line stream, in strict ping-pong order.
// Rev    : 1.0 - initial release
//==============================================================================
module gbf_dbuf_loader
    import gbf_pkg::*;
#(
    parameter int GBF_DATA_BITWIDTH = GBF_DATA_BITWIDTH_DEF,
    parameter int GBF_ADDR_BITWIDTH = GBF_ADDR_BITWIDTH_DEF,
    parameter int GBF_DEPTH         = GBF_DEPTH_DEF,
    parameter int FILL_LINES        = FILL_LINES_DEF,
    parameter int CNT_BITWIDTH      = CNT_BITWIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_BITWIDTH-1:0] num_fills,
    input  logic                    need_data1,
    input  logic                    need_data2,
    output logic                    buf1_ready,
    output logic                    buf2_ready,
    output logic                    data_avail,
    output logic                    done,
    gbf_dbuf_loader_if.master       bus
);

    // Tile length kept inside the buffer so a bad override cannot overrun it
    localparam int C_FILL = (FILL_LINES < 1)         ? 1 :
                            (FILL_LINES > GBF_DEPTH) ? GBF_DEPTH : FILL_LINES;
    localparam logic [GBF_ADDR_BITWIDTH-1:0] C_LAST = GBF_ADDR_BITWIDTH'(C_FILL - 1);

    state_t                        state_q,      state_d;
    logic                          next_buf_q,   next_buf_d;   // 0 = buf1, 1 = buf2
    logic [GBF_ADDR_BITWIDTH-1:0]  count_q,      count_d;
    logic [CNT_BITWIDTH-1:0]       remaining_q,  remaining_d;
    logic                          data_avail_q, data_avail_d;

    logic w_src_ready;
    logic w_hs;
    logic w_last;
    logic w_job_start;
    logic w_wr1, w_wr2;
    logic w_full1, w_full2;

    // Handshake and per-buffer write qualifiers
    always_comb begin
        w_src_ready = (state_q == ST_FILL1) || (state_q == ST_FILL2);
        w_hs        = bus.src_valid & w_src_ready;
        w_last      = w_hs && (count_q == C_LAST);
        w_job_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        w_wr1       = w_hs && (state_q == ST_FILL1);
        w_wr2       = w_hs && (state_q == ST_FILL2);
    end

    // FSM next-state and job bookkeeping
    always_comb begin
        state_d      = state_q;
        next_buf_d   = next_buf_q;
        count_d      = count_q;
        remaining_d  = remaining_q;
        data_avail_d = data_avail_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    remaining_d  = num_fills;
                    next_buf_d   = 1'b0;
                    data_avail_d = 1'b0;
                    state_d      = (num_fills == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!next_buf_q && !w_full1) begin
                    state_d = ST_FILL1;
                    count_d = '0;
                end else if (next_buf_q && !w_full2) begin
                    state_d = ST_FILL2;
                    count_d = '0;
                end
            end
            ST_FILL1, ST_FILL2: begin
                if (w_hs) begin
                    count_d = count_q + 1'b1;
                    if (w_last) begin
                        remaining_d  = remaining_q - 1'b1;
                        next_buf_d   = ~next_buf_q;
                        data_avail_d = 1'b1;
                        state_d      = (remaining_q == CNT_BITWIDTH'(1)) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            next_buf_q   <= 1'b0;
            count_q      <= '0;
            remaining_q  <= '0;
            data_avail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_buf_q   <= next_buf_d;
            count_q      <= count_d;
            remaining_q  <= remaining_d;
            data_avail_q <= data_avail_d;
        end
    end

    gbf_port_driver #(
        .GBF_DATA_BITWIDTH (GBF_DATA_BITWIDTH),
        .GBF_ADDR_BITWIDTH (GBF_ADDR_BITWIDTH)
    ) u_buf1 (
        .clk          (clk),
        .rst          (reset),
        .i_wr         (w_wr1),
        .i_set_full   (w_wr1 & w_last),
        .i_clear_full (w_job_start),
        .i_addr       (count_q),
        .i_data       (bus.src_data),
        .i_need_data  (need_data1),
        .o_en         (bus.en1a),
        .o_we         (bus.we1a),
        .o_addr       (bus.addr1a),
        .o_data       (bus.w_data1a),
        .o_full       (w_full1)
    );

    gbf_port_driver #(
        .GBF_DATA_BITWIDTH (GBF_DATA_BITWIDTH),
        .GBF_ADDR_BITWIDTH (GBF_ADDR_BITWIDTH)
    ) u_buf2 (
        .clk          (clk),
        .rst          (reset),
        .i_wr         (w_wr2),
        .i_set_full   (w_wr2 & w_last),
        .i_clear_full (w_job_start),
        .i_addr       (count_q),
        .i_data       (bus.src_data),
        .i_need_data  (need_data2),
        .o_en         (bus.en2a),
        .o_we         (bus.we2a),
        .o_addr       (bus.addr2a),
        .o_data       (bus.w_data2a),
        .o_full       (w_full2)
    );

    assign bus.src_ready = w_src_ready;
    assign buf1_ready    = w_full1;
    assign buf2_ready    = w_full2;
    assign data_avail    = data_avail_q;
    assign done          = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gbf_dbuf_loader.sv
`default_nettype none
//==============================================================================
// Module : tb_gbf_dbuf_loader
// Desc   : Self-checking bench for gbf_dbuf_loader (FILL_LINES = 4).
// Rev    : 1.0 - initial release
//==============================================================================
module tb_gbf_dbuf_loader;

    localparam int DW = 256;
    localparam int AW = 5;
    localparam int FL = 4;

    typedef struct {
        int           bsel;
        int           addr;
        logic [DW-1:0] data;
        logic         we;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_fills = '0;
    logic        need_data1 = 1'b0;
    logic        need_data2 = 1'b0;
    logic        buf1_ready, buf2_ready, data_avail, done;

    gbf_dbuf_loader_if #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW)) bus ();

    gbf_dbuf_loader #(
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (32),
        .FILL_LINES        (FL),
        .CNT_BITWIDTH      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_fills  (num_fills),
        .need_data1 (need_data1),
        .need_data2 (need_data2),
        .buf1_ready (buf1_ready),
        .buf2_ready (buf2_ready),
        .data_avail (data_avail),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  last_hs_cyc = 0;
    int  b1_rise_cyc = -1;
    int  m_buf = 1;
    int  m_addr = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    wr_t e, o;

    // Advance one cycle, sample after the edge and log any write-port activity
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.en1a || bus.en2a) begin
            w.bsel = (bus.en1a && bus.en2a) ? 3 : (bus.en1a ? 1 : 2);
            w.addr = bus.en1a ? int'(bus.addr1a) : int'(bus.addr2a);
            w.data = bus.en1a ? bus.w_data1a : bus.w_data2a;
            w.we   = bus.en1a ? bus.we1a : bus.we2a;
            obs_q.push_back(w);
        end
        if (buf1_ready && b1_rise_cyc < 0) b1_rise_cyc = cyc;
    endtask

    // Reference model: ping-pong buffers, addresses 0..FL-1 per tile
    task automatic model_push(input logic [DW-1:0] d);
        wr_t w;
        w.bsel = m_buf;
        w.addr = m_addr;
        w.data = d;
        w.we   = 1'b1;
        exp_q.push_back(w);
        m_addr++;
        if (m_addr == FL) begin
            m_addr = 0;
            m_buf  = 3 - m_buf;
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_fills = 16'(n);
        tick();
        start  = 1'b0;
        m_buf  = 1;
        m_addr = 0;
    endtask

    // Offer lines until n are accepted; data = base + line index
    task automatic drive_lines(input int n, input bit toggle, input int base);
        int got = 0;
        int budget = 0;
        logic [DW-1:0] d;
        while (got < n && budget < 200) begin
            d = '0;
            d[31:0] = base + got;
            bus.src_valid = toggle ? ((budget % 2) == 0) : 1'b1;
            bus.src_data  = d;
            if (bus.src_valid && bus.src_ready) begin
                model_push(d);
                last_hs_cyc = cyc;
                got++;
            end
            tick();
            budget++;
        end
        bus.src_valid = 1'b0;
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drive_timeout: accepted %0d lines, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.src_ready !== 1'b0) begin n_bad++; $display("FAIL reset_src_ready: got %b want 0", bus.src_ready); end
        n_cmp++; if ({bus.en1a, bus.we1a, bus.en2a, bus.we2a} !== 4'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0000", {bus.en1a, bus.we1a, bus.en2a, bus.we2a}); end
        n_cmp++; if ({bus.addr1a, bus.addr2a} !== '0 || bus.w_data1a !== '0 || bus.w_data2a !== '0) begin n_bad++; $display("FAIL reset_addr_data: addr1 %0d addr2 %0d want 0", bus.addr1a, bus.addr2a); end
        n_cmp++; if ({buf1_ready, buf2_ready, data_avail, done} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {buf1_ready, buf2_ready, data_avail, done}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_fill();
        do_start(2);
        b1_rise_cyc = -1;
        drive_lines(8, 1'b0, 0);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.bsel !== e.bsel || o.addr !== e.addr || o.data !== e.data || o.we !== 1'b1) begin
                n_bad++; $display("FAIL basic_write: got buf%0d addr %0d data %0h we %b, want buf%0d addr %0d data %0h we 1", o.bsel, o.addr, o.data[31:0], o.we, e.bsel, e.addr, e.data[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if ({buf1_ready, buf2_ready, data_avail, done} !== 4'b1111) begin n_bad++; $display("FAIL basic_end_flags: got %b want 1111", {buf1_ready, buf2_ready, data_avail, done}); end
        n_cmp++; if (bus.src_ready !== 1'b0) begin n_bad++; $display("FAIL basic_done_ready: got %b want 0", bus.src_ready); end
    endtask

    task automatic test_backpressure();
        do_start(1);
        b1_rise_cyc = -1;
        drive_lines(4, 1'b1, 20);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.bsel !== e.bsel || o.addr !== e.addr || o.data !== e.data || o.we !== 1'b1) begin
                n_bad++; $display("FAIL bp_write: got buf%0d addr %0d data %0h we %b, want buf%0d addr %0d data %0h we 1", o.bsel, o.addr, o.data[31:0], o.we, e.bsel, e.addr, e.data[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (b1_rise_cyc !== last_hs_cyc + 1) begin n_bad++; $display("FAIL bp_ready_rise: got cycle %0d want %0d", b1_rise_cyc, last_hs_cyc + 1); end
        n_cmp++; if ({buf1_ready, buf2_ready, done} !== 3'b101) begin n_bad++; $display("FAIL bp_end_flags: got %b want 101", {buf1_ready, buf2_ready, done}); end
    endtask

    task automatic test_release_refill();
        do_start(3);
        drive_lines(8, 1'b0, 0);
        bus.src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.src_ready !== 1'b0) begin n_bad++; $display("FAIL rel_wait_ready: got %b want 0", bus.src_ready); end
        end
        bus.src_valid = 1'b0;
        start = 1'b1; num_fills = '0;
        tick();
        start = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rel_start_ignored: done %b want 0", done); end
        need_data1 = 1'b1;
        tick();
        need_data1 = 1'b0;
        n_cmp++; if ({buf1_ready, buf2_ready} !== 2'b01) begin n_bad++; $display("FAIL rel_release: got %b want 01", {buf1_ready, buf2_ready}); end
        drive_lines(4, 1'b0, 8);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rel_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.bsel !== e.bsel || o.addr !== e.addr || o.data !== e.data || o.we !== 1'b1) begin
                n_bad++; $display("FAIL rel_write: got buf%0d addr %0d data %0h we %b, want buf%0d addr %0d data %0h we 1", o.bsel, o.addr, o.data[31:0], o.we, e.bsel, e.addr, e.data[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if ({buf1_ready, buf2_ready, done} !== 3'b111) begin n_bad++; $display("FAIL rel_end_flags: got %b want 111", {buf1_ready, buf2_ready, done}); end
    endtask

    task automatic test_ignored_edges();
        logic [DW-1:0] d;
        need_data2 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_start(3);
        drive_lines(2, 1'b0, 0);
        need_data1 = 1'b1;
        drive_lines(1, 1'b0, 2);
        need_data1 = 1'b0;
        drive_lines(1, 1'b0, 3);
        n_cmp++; if (buf1_ready !== 1'b1) begin n_bad++; $display("FAIL ign_fill_edge: buf1_ready %b want 1", buf1_ready); end
        drive_lines(4, 1'b0, 4);
        tick(); tick(); tick();
        n_cmp++; if ({buf2_ready, bus.src_ready} !== 2'b10) begin n_bad++; $display("FAIL ign_held_high: buf2_ready,src_ready %b want 10", {buf2_ready, bus.src_ready}); end
        need_data1 = 1'b1;
        tick();
        need_data1 = 1'b0;
        n_cmp++; if (buf1_ready !== 1'b0) begin n_bad++; $display("FAIL ign_release: buf1_ready %b want 0", buf1_ready); end
        drive_lines(3, 1'b0, 8);
        d = '0; d[31:0] = 11;
        bus.src_valid = 1'b1;
        bus.src_data  = d;
        need_data1    = 1'b1;
        n_cmp++; if (bus.src_ready !== 1'b1) begin n_bad++; $display("FAIL ign_last_ready: src_ready %b want 1", bus.src_ready); end
        model_push(d);
        tick();
        bus.src_valid = 1'b0;
        n_cmp++; if ({buf1_ready, done} !== 2'b11) begin n_bad++; $display("FAIL ign_coincident: buf1_ready,done %b want 11", {buf1_ready, done}); end
        tick();
        need_data1 = 1'b0;
        tick();
        n_cmp++; if (buf1_ready !== 1'b1) begin n_bad++; $display("FAIL ign_coincident_hold: buf1_ready %b want 1", buf1_ready); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ign_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.bsel !== e.bsel || o.addr !== e.addr || o.data !== e.data || o.we !== 1'b1) begin
                n_bad++; $display("FAIL ign_write: got buf%0d addr %0d data %0h we %b, want buf%0d addr %0d data %0h we 1", o.bsel, o.addr, o.data[31:0], o.we, e.bsel, e.addr, e.data[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        need_data2 = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        do_start(2);
        drive_lines(2, 1'b0, 0);
        n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL rmf_pre_count: got %0d writes want 2", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.en1a, bus.we1a, bus.addr1a} !== '0 || bus.w_data1a !== '0) begin n_bad++; $display("FAIL rmf_port1: en %b addr %0d data %0h want 0", bus.en1a, bus.addr1a, bus.w_data1a[31:0]); end
        n_cmp++; if ({bus.src_ready, buf1_ready, buf2_ready, data_avail, done} !== 5'b0) begin n_bad++; $display("FAIL rmf_flags: got %b want 00000", {bus.src_ready, buf1_ready, buf2_ready, data_avail, done}); end
        reset = 1'b0;
        obs_q.delete();
        tick();
        do_start(1);
        drive_lines(4, 1'b0, 100);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rmf_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o.bsel !== e.bsel || o.addr !== e.addr || o.data !== e.data || o.we !== 1'b1) begin
                n_bad++; $display("FAIL rmf_write: got buf%0d addr %0d data %0h we %b, want buf%0d addr %0d data %0h we 1", o.bsel, o.addr, o.data[31:0], o.we, e.bsel, e.addr, e.data[31:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if ({buf1_ready, buf2_ready, data_avail, done} !== 4'b1011) begin n_bad++; $display("FAIL rmf_end_flags: got %b want 1011", {buf1_ready, buf2_ready, data_avail, done}); end
    endtask

    task automatic test_zero_job();
        do_start(0);
        n_cmp++; if ({done, data_avail} !== 2'b10) begin n_bad++; $display("FAIL zero_done: done,data_avail %b want 10", {done, data_avail}); end
        bus.src_valid = 1'b1;
        tick(); tick(); tick();
        bus.src_valid = 1'b0;
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL zero_writes: got %0d writes want 0", obs_q.size()); end
        n_cmp++; if ({done, bus.src_ready, buf1_ready} !== 3'b100) begin n_bad++; $display("FAIL zero_hold: done,src_ready,buf1_ready %b want 100", {done, bus.src_ready, buf1_ready}); end
        obs_q.delete();
    endtask

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_release_refill();
        test_ignored_edges();
        test_reset_mid_fill();
        test_zero_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
